control_pipe: RTL and testbench
===============================

CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode width.
REQ-002 SHALL have parameter ALUOPW, default 4, ALU-op code width (min 4).
REQ-003 SHALL have parameter REGW, default 5, register-address width.
REQ-004 SHALL have parameter CNTW, default 8, illegal-opcode counter width.
REQ-005 SHALL have ports: clk in 1, single clock, rising edge; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ID inputs: id_valid in 1, ID instruction valid; id_opcode in OPW; id_rs in REGW; id_rt in REGW.
REQ-007 SHALL have input flush in 1: branch/jump taken, kill younger instructions.
REQ-008 SHALL have EX outputs: ex_valid out 1; ex_ctrl out 2 {ALUSrc,RegDst}; ex_aluop out ALUOPW; ex_m out 3 {Branch,MemWrite,MemRead}; ex_wb out 3 {Jump,RegWrite,MemToReg}; ex_rt out REGW.
REQ-009 SHALL have MEM outputs: mem_valid out 1; mem_m out 3; mem_wb out 3.
REQ-010 SHALL have WB outputs: wb_valid out 1; wb_wb out 3.
REQ-011 SHALL have status outputs: stall out 1 (combinational load-use hazard); ex_illegal out 1; illegal_count out CNTW.

Function
REQ-012 SHALL decode (ex_ctrl,ex_m,ex_wb,ex_aluop): 000000 R 01,000,010,2; 000010 J 00,000,100,0; 001000 addi 10,000,010,3; 001100 andi 10,000,010,4; 001101 ori 10,000,010,5; 001010 slti 10,000,010,6; 001110 xori 10,000,010,7; 101010 multi 10,000,010,8; 101111 subi 10,000,010,9; 110001 lw 10,001,011,0; 101011 sw 10,010,000,0; 000100 beq 00,100,000,1.
REQ-013 SHALL produce no X; decode of any unlisted opcode SHALL be a bubble (all fields 0).
REQ-014 SHALL register decode into ID/EX on each edge: latency ID->EX 1 cycle, ->MEM 2, ->WB 3.
REQ-015 SHALL zero-extend ex_aluop when ALUOPW>4; opcodes compare on low 6 bits, upper opcode bits when OPW>6 SHALL be 0 for a match.
REQ-016 SHALL advance EX/MEM from ID/EX (m,wb,valid) and MEM/WB from EX/MEM (wb,valid) each edge.
REQ-017 SHALL assert stall when id_valid & ex_valid & ex_m[0] & ex_rt!=0 & (ex_rt==id_rs | (ex_rt==id_rt & id opcode is R, sw or beq)), and flush=0.
REQ-018 SHALL, when stall=1, load ID/EX with bubble (valid=0, fields 0); EX/MEM, MEM/WB advance normally; upstream holds ID.
REQ-019 SHALL, when flush=1, load ID/EX and EX/MEM with bubbles; MEM/WB loads from EX/MEM normally.
REQ-020 SHALL give flush priority over stall; stall output forced 0 while flush=1.
REQ-021 SHALL load ID/EX bubble when id_valid=0.
REQ-022 SHALL set ex_illegal=1 for exactly the cycle after an unlisted opcode with id_valid=1, flush=0, stall=0; ex_valid=0 in that cycle.
REQ-023 SHALL increment illegal_count by 1 per ex_illegal pulse, saturating at all-ones (no wrap).
REQ-024 SHALL consider an instruction entering ID/EX during a stalled cycle not loaded; no illegal pulse for it until accepted.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear all valid bits, control fields, ex_rt, ex_illegal and illegal_count to 0.
REQ-026 SHALL give rst priority over flush, stall and id_valid; mid-pipeline instructions are discarded.
REQ-027 SHALL hold stall=0 during reset cycles as all ex_valid=0.

Verification
REQ-028 SHALL verify: addi (001000) id_valid=1 -> next cycle ex_ctrl=10, ex_wb=010, ex_aluop=3; mem_wb=010 one cycle later; wb_wb=010 one more.
REQ-029 SHALL verify: lw rt=5 then R-type rs=5 -> stall=1 one cycle, ex_valid=0 next, R-type accepted cycle after, stall=0.
REQ-030 SHALL verify: lw rt=0 then R-type rs=0 -> stall=0 (r0 exempt).
REQ-031 SHALL verify: flush=1 with lw in EX and beq in MEM -> next edge ex_valid=0, mem_valid=0, wb_valid=1 with wb_wb=000.
REQ-032 SHALL verify: opcode 111111 id_valid=1 x300 cycles -> ex_illegal pulses, ex_valid=0, illegal_count saturates at 255.
REQ-033 SHALL verify: rst asserted with all stages valid -> next edge all valid=0, illegal_count=0, stall=0.

Source files
------------

// File: rtl/control_pipe.sv
// Control path of a 5-stage pipeline: decodes ID opcodes into EX/MEM/WB control
// fields, detects load-use hazards, handles flush, and counts illegal opcodes.
module control_pipe #(
   parameter int unsigned OPW    = 6,
   parameter int unsigned ALUOPW = 4,
   parameter int unsigned REGW   = 5,
   parameter int unsigned CNTW   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [OPW-1:0]    id_opcode,
   input  logic [REGW-1:0]   id_rs,
   input  logic [REGW-1:0]   id_rt,
   input  logic              flush,
   output logic              ex_valid,
   output logic [1:0]        ex_ctrl,
   output logic [ALUOPW-1:0] ex_aluop,
   output logic [2:0]        ex_m,
   output logic [2:0]        ex_wb,
   output logic [REGW-1:0]   ex_rt,
   output logic              mem_valid,
   output logic [2:0]        mem_m,
   output logic [2:0]        mem_wb,
   output logic              wb_valid,
   output logic [2:0]        wb_wb,
   output logic              stall,
   output logic              ex_illegal,
   output logic [CNTW-1:0]   illegal_count
);

   localparam int unsigned BASEW = 6;

   logic             hi_zero;
   logic [BASEW-1:0] op6;
   logic             dec_legal;
   logic             dec_uses_rt;
   logic [1:0]       dec_ctrl;
   logic [2:0]       dec_m;
   logic [2:0]       dec_wb;
   logic [3:0]       dec_alu;
   logic             accept;
   logic             load_ex;

   assign op6     = id_opcode[BASEW-1:0];
   assign hi_zero = ((id_opcode >> BASEW) == '0);

   // Opcode decode; anything unlisted decodes to an all-zero bubble
   always_comb begin
      dec_legal   = 1'b0;
      dec_uses_rt = 1'b0;
      dec_ctrl    = 2'b00;
      dec_m       = 3'b000;
      dec_wb      = 3'b000;
      dec_alu     = 4'd0;
      if (hi_zero) begin
         case (op6)
            6'b000000: begin dec_legal = 1'b1; dec_uses_rt = 1'b1; dec_ctrl = 2'b01; dec_wb = 3'b010; dec_alu = 4'd2; end
            6'b000010: begin dec_legal = 1'b1; dec_wb = 3'b100; end
            6'b001000: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd3; end
            6'b001100: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd4; end
            6'b001101: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd5; end
            6'b001010: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd6; end
            6'b001110: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd7; end
            6'b101010: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd8; end
            6'b101111: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_wb = 3'b010; dec_alu = 4'd9; end
            6'b110001: begin dec_legal = 1'b1; dec_ctrl = 2'b10; dec_m = 3'b001; dec_wb = 3'b011; end
            6'b101011: begin dec_legal = 1'b1; dec_uses_rt = 1'b1; dec_ctrl = 2'b10; dec_m = 3'b010; end
            6'b000100: begin dec_legal = 1'b1; dec_uses_rt = 1'b1; dec_m = 3'b100; dec_alu = 4'd1; end
            default:   begin dec_legal = 1'b0; end
         endcase
      end
   end

   // Load-use hazard against a load sitting in EX; r0 never creates a dependency
   always_comb begin
      stall = 1'b0;
      if (!rst && !flush && id_valid && ex_valid && ex_m[0] && (ex_rt != '0)) begin
         stall = (ex_rt == id_rs) || ((ex_rt == id_rt) && dec_uses_rt);
      end
   end

   assign accept  = id_valid && !flush && !stall;
   assign load_ex = accept && dec_legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_ctrl       <= '0;
         ex_aluop      <= '0;
         ex_m          <= '0;
         ex_wb         <= '0;
         ex_rt         <= '0;
         ex_illegal    <= 1'b0;
         illegal_count <= '0;
         mem_valid     <= 1'b0;
         mem_m         <= '0;
         mem_wb        <= '0;
         wb_valid      <= 1'b0;
         wb_wb         <= '0;
      end else begin
         ex_valid   <= load_ex;
         ex_ctrl    <= load_ex ? dec_ctrl : 2'b00;
         ex_aluop   <= load_ex ? ALUOPW'(dec_alu) : '0;
         ex_m       <= load_ex ? dec_m : 3'b000;
         ex_wb      <= load_ex ? dec_wb : 3'b000;
         ex_rt      <= load_ex ? id_rt : '0;
         ex_illegal <= accept && !dec_legal;
         if (accept && !dec_legal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + CNTW'(1);
         end
         // Flush kills the instruction moving EX->MEM; older work drains to WB
         if (flush) begin
            mem_valid <= 1'b0;
            mem_m     <= '0;
            mem_wb    <= '0;
         end else begin
            mem_valid <= ex_valid;
            mem_m     <= ex_m;
            mem_wb    <= ex_wb;
         end
         wb_valid <= mem_valid;
         wb_wb    <= mem_wb;
      end
   end

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: table-driven pipeline model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_control_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [5:0] id_opcode;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       flush;
   logic       ex_valid;
   logic [1:0] ex_ctrl;
   logic [3:0] ex_aluop;
   logic [2:0] ex_m;
   logic [2:0] ex_wb;
   logic [4:0] ex_rt;
   logic       mem_valid;
   logic [2:0] mem_m;
   logic [2:0] mem_wb;
   logic       wb_valid;
   logic [2:0] wb_wb;
   logic       stall;
   logic       ex_illegal;
   logic [7:0] illegal_count;

   control_pipe dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_aluop(ex_aluop), .ex_m(ex_m),
      .ex_wb(ex_wb), .ex_rt(ex_rt), .mem_valid(mem_valid), .mem_m(mem_m),
      .mem_wb(mem_wb), .wb_valid(wb_valid), .wb_wb(wb_wb), .stall(stall),
      .ex_illegal(ex_illegal), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                          OP_LW = 6'b110001, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                          OP_BAD = 6'b111111;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Decode table rows: {opcode, ctrl, m, wb, aluop}
   logic [17:0] tbl [12];
   initial begin
      tbl[0]  = {6'b000000, 2'b01, 3'b000, 3'b010, 4'd2};
      tbl[1]  = {6'b000010, 2'b00, 3'b000, 3'b100, 4'd0};
      tbl[2]  = {6'b001000, 2'b10, 3'b000, 3'b010, 4'd3};
      tbl[3]  = {6'b001100, 2'b10, 3'b000, 3'b010, 4'd4};
      tbl[4]  = {6'b001101, 2'b10, 3'b000, 3'b010, 4'd5};
      tbl[5]  = {6'b001010, 2'b10, 3'b000, 3'b010, 4'd6};
      tbl[6]  = {6'b001110, 2'b10, 3'b000, 3'b010, 4'd7};
      tbl[7]  = {6'b101010, 2'b10, 3'b000, 3'b010, 4'd8};
      tbl[8]  = {6'b101111, 2'b10, 3'b000, 3'b010, 4'd9};
      tbl[9]  = {6'b110001, 2'b10, 3'b001, 3'b011, 4'd0};
      tbl[10] = {6'b101011, 2'b10, 3'b010, 3'b000, 4'd0};
      tbl[11] = {6'b000100, 2'b00, 3'b100, 3'b000, 4'd1};
   end

   // Model state: what each stage should hold
   typedef struct packed {
      logic       v;
      logic [1:0] ctrl;
      logic [2:0] m;
      logic [2:0] wb;
      logic [3:0] alu;
      logic [4:0] rt;
   } stage_t;

   stage_t     m_ex, m_mem, m_wbs, m_new;
   logic       m_ill;
   int         m_cnt;
   bit         hit, st, acc;
   logic [17:0] row;
   bit         chk_en = 1'b0;

   function automatic bit exp_stall();
      bit uses_rt;
      uses_rt = (id_opcode == OP_R) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
      return !rst && !flush && id_valid && m_ex.v && m_ex.m[0] && (m_ex.rt != 5'd0) &&
             ((m_ex.rt == id_rs) || ((m_ex.rt == id_rt) && uses_rt));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ex = '0; m_mem = '0; m_wbs = '0; m_ill = 1'b0; m_cnt = 0;
      end else begin
         st  = exp_stall();
         acc = id_valid && !flush && !st;
         hit = 1'b0;
         row = '0;
         for (int i = 0; i < 12; i++) begin
            if (tbl[i][17:12] == id_opcode) begin
               hit = 1'b1;
               row = tbl[i];
            end
         end
         m_new = '0;
         if (acc && hit) m_new = {1'b1, row[11:10], row[9:7], row[6:4], row[3:0], id_rt};
         m_wbs = m_mem;
         m_mem = flush ? '0 : m_ex;
         m_ex  = m_new;
         m_ill = acc && !hit;
         if (m_ill && m_cnt < 255) m_cnt++;
      end
      chk_en = 1'b1;
   end

   // Every-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ex_valid", 32'(ex_valid), 32'(m_ex.v));
         chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ex.ctrl));
         chk("ex_aluop", 32'(ex_aluop), 32'(m_ex.alu));
         chk("ex_m", 32'(ex_m), 32'(m_ex.m));
         chk("ex_wb", 32'(ex_wb), 32'(m_ex.wb));
         chk("ex_rt", 32'(ex_rt), 32'(m_ex.rt));
         chk("mem_valid", 32'(mem_valid), 32'(m_mem.v));
         chk("mem_m", 32'(mem_m), 32'(m_mem.m));
         chk("mem_wb", 32'(mem_wb), 32'(m_mem.wb));
         chk("wb_valid", 32'(wb_valid), 32'(m_wbs.v));
         chk("wb_wb", 32'(wb_wb), 32'(m_wbs.wb));
         chk("stall", 32'(stall), 32'(exp_stall()));
         chk("ex_illegal", 32'(ex_illegal), 32'(m_ill));
         chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
      end
   end

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic fl, input logic r);
      id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; flush = fl; rst = r;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      drive(1'b0, OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      drive(1'b0, OP_R, 5'd0, 5'd0, 1'b0, 1'b1);
      step(); step();
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_count", 32'(illegal_count), 32'd0);

      // addi flows through EX, MEM, WB
      drive(1'b1, OP_ADDI, 5'd1, 5'd2, 1'b0, 1'b0);
      step();
      chk("addi_ex_ctrl", 32'(ex_ctrl), 32'b10);
      chk("addi_ex_wb", 32'(ex_wb), 32'b010);
      chk("addi_ex_aluop", 32'(ex_aluop), 32'd3);
      idle(); step();
      chk("addi_mem_wb", 32'(mem_wb), 32'b010);
      step();
      chk("addi_wb_wb", 32'(wb_wb), 32'b010);
      chk("addi_wb_valid", 32'(wb_valid), 32'd1);

      // Every listed opcode back-to-back, no dependencies
      for (int i = 0; i < 12; i++) begin
         row = tbl[i];
         drive(1'b1, row[17:12], 5'(i + 1), 5'(i + 14), 1'b0, 1'b0);
         step();
      end
      idle(); step(); step(); step();

      // Load-use on rs: one stall, bubble, then the R-type is accepted
      drive(1'b1, OP_LW, 5'd1, 5'd5, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_R, 5'd5, 5'd9, 1'b0, 1'b0);
      #1 chk("lu_stall", 32'(stall), 32'd1);
      step();
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      chk("lu_stall_clear", 32'(stall), 32'd0);
      step();
      chk("lu_accept", 32'(ex_valid), 32'd1);
      chk("lu_accept_alu", 32'(ex_aluop), 32'd2);
      idle(); step(); step();

      // rt dependency: sw stalls, addi (rt is a destination) does not
      drive(1'b1, OP_LW, 5'd1, 5'd7, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_SW, 5'd3, 5'd7, 1'b0, 1'b0);
      #1 chk("sw_rt_stall", 32'(stall), 32'd1);
      drive(1'b1, OP_ADDI, 5'd3, 5'd7, 1'b0, 1'b0);
      #1 chk("addi_rt_nostall", 32'(stall), 32'd0);
      step(); idle(); step(); step();

      // r0 is exempt
      drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      #1 chk("r0_nostall", 32'(stall), 32'd0);
      step(); idle(); step(); step(); step();

      // Flush with lw in EX and beq in MEM; a would-be hazard is overridden
      drive(1'b1, OP_BEQ, 5'd1, 5'd2, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_LW, 5'd1, 5'd6, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_R, 5'd6, 5'd1, 1'b1, 1'b0);
      #1 chk("flush_stall_forced0", 32'(stall), 32'd0);
      step();
      chk("flush_ex_valid", 32'(ex_valid), 32'd0);
      chk("flush_mem_valid", 32'(mem_valid), 32'd0);
      chk("flush_wb_valid", 32'(wb_valid), 32'd1);
      chk("flush_wb_wb", 32'(wb_wb), 32'b000);
      idle(); step(); step();

      // Illegal under flush does not count
      drive(1'b1, OP_BAD, 5'd0, 5'd0, 1'b1, 1'b0);
      step();
      chk("flush_no_illegal", 32'(ex_illegal), 32'd0);

      // Illegal opcode stream saturates the counter
      drive(1'b1, OP_BAD, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      chk("ill_pulse", 32'(ex_illegal), 32'd1);
      chk("ill_ex_valid", 32'(ex_valid), 32'd0);
      chk("ill_count1", 32'(illegal_count), 32'd1);
      for (int i = 1; i < 300; i++) step();
      chk("ill_saturated", 32'(illegal_count), 32'd255);
      idle(); step();
      chk("ill_pulse_end", 32'(ex_illegal), 32'd0);

      // Reset with all stages valid and a hazard pending
      drive(1'b1, OP_ADDI, 5'd1, 5'd2, 1'b0, 1'b0);
      step(); step();
      drive(1'b1, OP_LW, 5'd1, 5'd4, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_R, 5'd4, 5'd1, 1'b0, 1'b1);
      #1 chk("rst_stall0", 32'(stall), 32'd0);
      step();
      chk("rst2_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst2_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst2_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst2_count", 32'(illegal_count), 32'd0);
      idle(); step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
